uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a configurable frame format and an input FIFO. Byte producers (crypto core result path, status reporter) push words with a valid/ready handshake. The block serialises them back-to-back on a single TX line with no inter-frame gaps while the FIFO holds data. Frame format (parity mode, stop bits) is selectable at runtime and latched per frame.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo_if.sv | 11 +
 rtl/uart_sync_fifo.sv | 47 ++++
 rtl/uart_tx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encoding, transmitter FSM states, baud divider.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } par_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready word handshake into the UART transmitter.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered read data; rd_data is valid the cycle after a pop.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
        if (do_pop)  rd_data     <= mem[rd_ptr];
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter; frames go out back-to-back while words are queued,
// with parity mode and stop-bit count captured at the start of each frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               bus,
    input  logic [1:0]                  parity_mode,
    input  logic                        two_stop,
    output logic                        tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    tx_state_e            state, state_n;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 data_xor, data_xor_n;
    logic [1:0]           par_l, par_l_n;
    logic                 two_l, two_l_n;
    logic                 pend, pend_n;
    logic                 tx_n;
    logic                 busy_n;
    logic                 ready_en;
    logic                 bit_end;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] rd_data;
    logic [CW-1:0]        cnt_nxt;

    uart_sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_data(bus.in_data),
        .pop    (pop),
        .rd_data(rd_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // ready_en keeps in_ready low until the first edge after reset is released
    assign bus.in_ready = ready_en && !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;
    assign bit_end      = (bit_cnt == CNT_W'(CPB - 1));
    assign cnt_nxt      = fifo_count + CW'(push) - CW'(pop);
    assign busy_n       = (state_n != IDLE) || pend_n || (cnt_nxt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            idx      <= '0;
            par_l    <= '0;
            two_l    <= 1'b0;
            pend     <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            idx      <= idx_n;
            par_l    <= par_l_n;
            two_l    <= two_l_n;
            pend     <= pend_n;
            tx       <= tx_n;
            tx_busy  <= busy_n;
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        shreg    <= shreg_n;
        data_xor <= data_xor_n;
    end

    // pend marks a popped word whose registered FIFO read data lands next cycle
    always_comb begin
        state_n    = state;
        bit_cnt_n  = '0;
        idx_n      = idx;
        shreg_n    = shreg;
        data_xor_n = data_xor;
        par_l_n    = par_l;
        two_l_n    = two_l;
        pend_n     = pend;
        tx_n       = tx;
        pop        = 1'b0;

        if (state != IDLE) begin
            bit_cnt_n = bit_end ? '0 : bit_cnt + CNT_W'(1);
        end
        if (pend && state != IDLE) begin
            shreg_n    = rd_data;
            data_xor_n = ^rd_data;
            pend_n     = 1'b0;
        end

        unique case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (pend) begin
                    shreg_n    = rd_data;
                    data_xor_n = ^rd_data;
                    pend_n     = 1'b0;
                    par_l_n    = parity_mode;
                    two_l_n    = two_stop;
                    tx_n       = 1'b0;
                    state_n    = START;
                end else if (!fifo_empty) begin
                    pop    = 1'b1;
                    pend_n = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                    tx_n    = shreg[0];
                    shreg_n = shreg >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_n = '0;
                        if (par_l == PAR_EVEN || par_l == PAR_ODD) begin
                            state_n = PARITY;
                            tx_n    = data_xor ^ (par_l == PAR_ODD);
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        tx_n    = shreg[0];
                        shreg_n = shreg >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    idx_n   = '0;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (two_l && idx == '0) begin
                        idx_n = IDX_W'(1);
                    end else begin
                        idx_n = '0;
                        // chain straight into the next start bit when more data is queued
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            pend_n  = 1'b1;
                            par_l_n = parity_mode;
                            two_l_n = two_stop;
                            tx_n    = 1'b0;
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                            tx_n    = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 16 clocks per bit, 8 data bits, 4-entry FIFO.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] parity_mode = 2'd0;
    logic       two_stop = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo_if #(.DATA_BITS(8)) bus ();

    uart_tx_fifo #(
        .CLK_FREQ  (16),
        .BAUD_RATE (1),
        .DATA_BITS (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  mode;
        logic        two;
        int          nbits;
        int          exp_len;
        logic [11:0] exp_bits;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        int w;
        w = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Push one word and record start latency, start-to-idle length and mid-bit samples.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] m, input logic two,
                             input int nbits, output int lat, output int len,
                             output logic [11:0] bits);
        lat  = -1;
        len  = -1;
        bits = '0;
        @(negedge clk);
        parity_mode = m;
        two_stop    = two;
        push_word(d);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (lat < 0 && tx === 1'b0) lat = k;
            if (lat >= 0 && k >= lat + 8 && ((k - lat - 8) % 16) == 0 && (k - lat - 8) / 16 < nbits)
                bits[(k - lat - 8) / 16] = tx;
            if (lat >= 0 && tx_busy === 1'b0) begin
                len = k - lat;
                break;
            end
        end
    endtask

    // Line receiver: returns at the middle of the first stop bit.
    task automatic decode_byte(input logic par_en, output logic [7:0] d, output logic p,
                               output logic ok);
        int t;
        t  = 0;
        d  = '0;
        p  = 1'b0;
        ok = 1'b0;
        while (tx !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) return;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            d[i] = tx;
        end
        if (par_en) begin
            repeat (16) @(negedge clk);
            p = tx;
        end
        repeat (16) @(negedge clk);
        ok = (tx === 1'b1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (tx_busy !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, len;
        logic [11:0] bits;
        logic [7:0]  d1, d2;
        logic        p1, p2, ok1, ok2;

        vecs[0] = '{8'hA5, 2'd0, 1'b0, 10, 160, {3'b001, 8'hA5, 1'b0}};
        vecs[1] = '{8'h07, 2'd1, 1'b0, 11, 176, {3'b011, 8'h07, 1'b0}};
        vecs[2] = '{8'h07, 2'd2, 1'b0, 11, 176, {3'b010, 8'h07, 1'b0}};
        vecs[3] = '{8'h3C, 2'd3, 1'b1, 11, 176, {3'b011, 8'h3C, 1'b0}};
        vecs[4] = '{8'h5A, 2'd1, 1'b1, 12, 192, {3'b110, 8'h5A, 1'b0}};

        bus.in_data  = '0;
        bus.in_valid = 1'b0;

        // reset state
        #2 rst = 1'b1;
        #20;
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_count", fifo_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // single frames across formats
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].data, vecs[i].mode, vecs[i].two, vecs[i].nbits, lat, len, bits);
            check($sformatf("v%0d_latency", i), lat, 2);
            check($sformatf("v%0d_length", i), len, vecs[i].exp_len);
            check($sformatf("v%0d_bits", i), bits, vecs[i].exp_bits);
        end

        // two stop bits, back-to-back frames: gap and no idle bit
        begin
            int         lat2, rise, low2, fall, off;
            logic [7:0] b2;
            lat2 = -1; rise = -1; low2 = -1; fall = -1; b2 = '0;
            @(negedge clk);
            parity_mode = 2'd0;
            two_stop    = 1'b1;
            push_word(8'h00);
            push_word(8'hFF);
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (lat2 < 0 && tx === 1'b0) lat2 = k;
                else if (lat2 >= 0 && rise < 0 && tx === 1'b1) rise = k;
                else if (rise >= 0 && low2 < 0 && tx === 1'b0) low2 = k;
                if (low2 >= 0) begin
                    off = k - low2 - 8;
                    if (off >= 16 && (off % 16) == 0 && off / 16 <= 8) b2[off / 16 - 1] = tx;
                    if (tx_busy === 1'b0) begin
                        fall = k;
                        break;
                    end
                end
            end
            check("b2b_stop_gap", low2 - rise, 32);
            check("b2b_frame2_data", b2, 8'hFF);
            check("b2b_frame2_length", fall - low2, 176);
        end

        // FIFO fills while in_valid is held; six words must come out in order
        begin
            logic [7:0] w [6];
            logic [7:0] got [6];
            logic       okf [6];
            int         max_cnt;
            logic       saw_low;
            w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
            max_cnt = 0;
            saw_low = 1'b0;
            @(negedge clk);
            parity_mode = 2'd0;
            two_stop    = 1'b0;
            fork
                begin
                    for (int i = 0; i < 6; i++) push_word(w[i]);
                end
                begin
                    logic pd;
                    for (int i = 0; i < 6; i++) decode_byte(1'b0, got[i], pd, okf[i]);
                end
                begin
                    repeat (300) begin
                        @(negedge clk);
                        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
                        if (!bus.in_ready) saw_low = 1'b1;
                    end
                end
            join
            check("full_max_count", max_cnt, 4);
            check("full_in_ready_dropped", saw_low, 1);
            for (int i = 0; i < 6; i++)
                check($sformatf("full_word%0d", i), {okf[i], got[i]}, {1'b1, w[i]});
            wait_idle();
            check("full_drained_busy", tx_busy, 0);
            check("full_drained_count", fifo_count, 0);
        end

        // parity mode changed mid-frame applies only to the following frame
        @(negedge clk);
        parity_mode = 2'd0;
        two_stop    = 1'b0;
        push_word(8'h81);
        push_word(8'h81);
        fork
            begin
                decode_byte(1'b0, d1, p1, ok1);
                decode_byte(1'b1, d2, p2, ok2);
            end
            begin
                repeat (60) @(negedge clk);
                parity_mode = 2'd1;
            end
        join
        check("parchg_frame1", {ok1, d1}, {1'b1, 8'h81});
        check("parchg_frame2_parity", p2, 0);
        check("parchg_frame2", {ok2, d2}, {1'b1, 8'h81});
        wait_idle();
        parity_mode = 2'd0;

        // reset during data bits, then a clean frame
        @(negedge clk);
        push_word(8'h00);
        push_word(8'h55);
        repeat (60) @(negedge clk);
        check("midrst_pre_tx", tx, 0);
        check("midrst_pre_count", fifo_count, 1);
        rst = 1'b1;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", tx_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(8'h3C, 2'd0, 1'b0, 10, lat, len, bits);
        check("after_rst_latency", lat, 2);
        check("after_rst_length", len, 160);
        check("after_rst_bits", bits, {3'b001, 8'h3C, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
